// File: rtl/sp_ram_req_master.sv
// Request/response adapter for a single-port SRAM: requests pass straight through, read data returns 2 cycles after accept.
// Read credits cap in-flight reads at RESP_DEPTH, so a stalled response port stops reads without ever dropping SRAM data.
module sp_ram_req_master #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_be_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    ram_en_o,
  output logic                    ram_we_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic                    idle_o
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = $clog2(RESP_DEPTH);

  logic [CW-1:0]         r_occ;
  logic                  r_pend;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [DATA_WIDTH-1:0] r_mem [RESP_DEPTH];

  logic                  w_pop;
  logic                  w_fire;
  logic                  w_rd_fire;
  logic [CW:0]           w_inflight;
  logic [PW-1:0]         w_wptr_nxt;
  logic [PW-1:0]         w_rptr_nxt;

  assign resp_valid_o = (r_occ != '0);
  assign w_pop        = resp_valid_o & resp_ready_i;

  // A pop this cycle frees its slot before the next read's data can land.
  assign w_inflight   = {1'b0, r_occ} + {{CW{1'b0}}, r_pend} - {{CW{1'b0}}, w_pop};
  assign req_ready_o  = (w_inflight < (CW+1)'(RESP_DEPTH));

  assign w_fire       = req_valid_i & req_ready_o;
  assign w_rd_fire    = w_fire & ~req_we_i;

  assign ram_en_o     = w_fire;
  assign ram_we_o     = w_fire & req_we_i;
  assign ram_addr_o   = req_addr_i;
  assign ram_wdata_o  = req_wdata_i;
  assign ram_be_o     = (req_valid_i & req_we_i) ? req_be_i : '0;

  assign w_wptr_nxt   = (r_wptr == PW'(RESP_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
  assign w_rptr_nxt   = (r_rptr == PW'(RESP_DEPTH - 1)) ? '0 : r_rptr + PW'(1);

  assign resp_rdata_o = resp_valid_o ? r_mem[r_rptr] : '0;
  assign idle_o       = (r_occ == '0) & ~r_pend;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_occ  <= '0;
      r_pend <= 1'b0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_pend <= w_rd_fire;
      r_occ  <= r_occ + CW'(r_pend) - CW'(w_pop);
      if (r_pend) r_wptr <= w_wptr_nxt;
      if (w_pop)  r_rptr <= w_rptr_nxt;
    end
  end

  // Storage needs no reset: an entry is only visible once counted in r_occ.
  always_ff @(posedge clk) begin
    if (r_pend) r_mem[r_wptr] <= ram_rdata_i;
  end

endmodule
